// File: rtl/memory_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : memory_responder
// Brief    : Fixed-latency scratchpad RAM responder for the MemoryIn/MemoryOut
//            protocol, with byte/halfword masking and sign/zero extension.
//            Optional misalignment error: MEMORY_RESPONDER_MISALIGN_ERR_EN.
// Encoding : mem_in  = {addr[31:0], data[31:0], fcn[1:0], typ[2:0], req_valid}
//            mem_out = {res_data[31:0], req_ready, res_valid}
//            fcn: 0 M_X, 1 M_XRD, 2 M_XWR, 3 no-op
//            typ: 0 X, 1 B, 2 H, 3 W, 5 BU, 6 HU, 7 WU (4 treated as word)
// Revision : 1.0 - initial release
// ============================================================================
module memory_responder #(
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [69:0] mem_in,
`ifdef MEMORY_RESPONDER_MISALIGN_ERR_EN
    output logic        res_err,
`endif
    output logic [33:0] mem_out
);

    localparam int         AW    = $clog2(DEPTH);
    localparam logic [3:0] LAT4  = 4'(LATENCY);

    localparam logic [1:0] M_XRD = 2'd1;
    localparam logic [1:0] M_XWR = 2'd2;

    localparam logic [2:0] MT_B  = 3'd1;
    localparam logic [2:0] MT_H  = 3'd2;
    localparam logic [2:0] MT_BU = 3'd5;
    localparam logic [2:0] MT_HU = 3'd6;

    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [1:0]    fcn;
    logic [2:0]    typ;
    logic          req_valid;
    logic [AW-1:0] idx;
    logic          unused_addr_bits;

    assign addr      = mem_in[69:38];
    assign wdata     = mem_in[37:6];
    assign fcn       = mem_in[5:4];
    assign typ       = mem_in[3:1];
    assign req_valid = mem_in[0];
    assign idx       = addr[AW+1:2];
    assign unused_addr_bits = ^addr[31:AW+2];

    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       req_ready;
    logic       res_valid;
    logic       accept;

    assign req_ready = (cnt <= 4'd1);
    assign res_valid = (cnt == 4'd1);
    assign accept    = req_valid && req_ready;

    logic is_load;
    logic is_store;
    logic is_byte;
    logic is_half;

    assign is_load  = (fcn == M_XRD);
    assign is_store = (fcn == M_XWR);
    assign is_byte  = (typ == MT_B) || (typ == MT_BU);
    assign is_half  = (typ == MT_H) || (typ == MT_HU);

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;
    logic [31:0] rsp_data;
    logic        wr_en;
    logic [3:0]  be;
    logic [31:0] wword;

    assign rd_word = mem[idx];
    assign rd_byte = rd_word[8*addr[1:0] +: 8];
    assign rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_val = rd_word;
        case (typ)
            MT_B:    load_val = {{24{rd_byte[7]}}, rd_byte};
            MT_BU:   load_val = {24'd0, rd_byte};
            MT_H:    load_val = {{16{rd_half[15]}}, rd_half};
            MT_HU:   load_val = {16'd0, rd_half};
            default: load_val = rd_word;
        endcase
    end

    always_comb begin
        be    = 4'b1111;
        wword = wdata;
        if (is_byte) begin
            be    = 4'b0001 << addr[1:0];
            wword = {4{wdata[7:0]}};
        end else if (is_half) begin
            be    = addr[1] ? 4'b1100 : 4'b0011;
            wword = {2{wdata[15:0]}};
        end
    end

`ifdef MEMORY_RESPONDER_MISALIGN_ERR_EN
    logic misaligned;
    logic access_err;

    assign misaligned = is_half ? addr[0] : (!is_byte && (addr[1:0] != 2'd0));
    assign access_err = misaligned && (is_load || is_store);
    assign rsp_data   = (is_load && !misaligned) ? load_val : 32'd0;
    assign wr_en      = accept && is_store && !misaligned;
`else
    // Low address bits below the access size are simply dropped by the lane logic.
    assign rsp_data   = is_load ? load_val : 32'd0;
    assign wr_en      = accept && is_store;
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wword[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        cnt_nxt = cnt;
        if (accept) begin
            cnt_nxt = LAT4;
        end else if (cnt != 4'd0) begin
            cnt_nxt = cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 4'd0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    // Result is staged in pend_data and only moved to the visible register on
    // entry to RESP, so res_data never changes while a longer access is waiting.
    logic [31:0] pend_data;
    logic [31:0] res_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_data <= 32'd0;
            res_data  <= 32'd0;
        end else begin
            if (accept) begin
                pend_data <= rsp_data;
            end
            if (accept && (LATENCY == 1)) begin
                res_data <= rsp_data;
            end else if (cnt == 4'd2) begin
                res_data <= pend_data;
            end
        end
    end

`ifdef MEMORY_RESPONDER_MISALIGN_ERR_EN
    logic pend_err;
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_err <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                pend_err <= access_err;
            end
            if (accept && (LATENCY == 1)) begin
                err_q <= access_err;
            end else if (cnt == 4'd2) begin
                err_q <= pend_err;
            end
        end
    end

    assign res_err = res_valid && err_q;
`endif

    assign mem_out = {res_data, req_ready, res_valid};

endmodule
`default_nettype wire

// File: tb/tb_memory_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_memory_responder
// Brief    : Directed bench for memory_responder at LATENCY=1 and LATENCY=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_responder;

    localparam logic [1:0] M_X   = 2'd0;
    localparam logic [1:0] M_XRD = 2'd1;
    localparam logic [1:0] M_XWR = 2'd2;
    localparam logic [2:0] MT_B  = 3'd1;
    localparam logic [2:0] MT_H  = 3'd2;
    localparam logic [2:0] MT_W  = 3'd3;
    localparam logic [2:0] MT_BU = 3'd5;
    localparam logic [2:0] MT_HU = 3'd6;

    logic        clk = 1'b0;
    logic        rst;
    logic [69:0] in1;
    logic [69:0] in3;
    logic [33:0] out1;
    logic [33:0] out3;
`ifdef MEMORY_RESPONDER_MISALIGN_ERR_EN
    logic        err1;
    logic        err3;
`endif

    always #5 clk = ~clk;

    memory_responder #(.DEPTH(4096), .LATENCY(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .mem_in  (in1),
`ifdef MEMORY_RESPONDER_MISALIGN_ERR_EN
        .res_err (err1),
`endif
        .mem_out (out1)
    );

    memory_responder #(.DEPTH(256), .LATENCY(3)) dut3 (
        .clk     (clk),
        .rst     (rst),
        .mem_in  (in3),
`ifdef MEMORY_RESPONDER_MISALIGN_ERR_EN
        .res_err (err3),
`endif
        .mem_out (out3)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [69:0] pk(input logic [31:0] a, input logic [31:0] d,
                                       input logic [1:0] f, input logic [2:0] t);
        return {a, d, f, t, 1'b1};
    endfunction

    // One isolated access on the LATENCY=1 instance; response checked one cycle later.
    task automatic acc1(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] f, input logic [2:0] t,
                        input logic [31:0] exp, input logic exp_err);
        @(negedge clk);
        in1 = pk(a, d, f, t);
        chk({tag, "_ready"}, {31'd0, out1[1]}, 32'd1);
        @(posedge clk);
        #1 in1 = '0;
        @(negedge clk);
        chk({tag, "_valid"}, {31'd0, out1[0]}, 32'd1);
        chk({tag, "_data"}, out1[33:2], exp);
`ifdef MEMORY_RESPONDER_MISALIGN_ERR_EN
        chk({tag, "_err"}, {31'd0, err1}, {31'd0, exp_err});
`else
        if (exp_err) $display("note: %s expects an error flag that this build lacks", tag);
`endif
    endtask

    // One isolated access on the LATENCY=3 instance.
    task automatic acc3(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] f, input logic [2:0] t, input logic [31:0] exp);
        @(negedge clk);
        in3 = pk(a, d, f, t);
        @(posedge clk);
        #1 in3 = '0;
        @(negedge clk);
        chk({tag, "_busy"}, {31'd0, out3[1]}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_valid"}, {31'd0, out3[0]}, 32'd1);
        chk({tag, "_data"}, out3[33:2], exp);
    endtask

    initial begin
        logic seen;
        rst = 1'b1;
        in1 = '0;
        in3 = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready1", {31'd0, out1[1]}, 32'd1);
        chk("rst_valid1", {31'd0, out1[0]}, 32'd0);
        chk("rst_data1",  out1[33:2], 32'd0);
        chk("rst_ready3", {31'd0, out3[1]}, 32'd1);
        chk("rst_valid3", {31'd0, out3[0]}, 32'd0);
`ifdef MEMORY_RESPONDER_MISALIGN_ERR_EN
        chk("rst_err1", {31'd0, err1}, 32'd0);
`endif
        rst = 1'b0;

        // Word store/load
        acc1("sw10", 32'h10, 32'hDEADBEEF, M_XWR, MT_W, 32'h0, 1'b0);
        acc1("lw10", 32'h10, 32'h0, M_XRD, MT_W, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        chk("idle_valid", {31'd0, out1[0]}, 32'd0);
        chk("idle_hold",  out1[33:2], 32'hDEADBEEF);

        // Byte/half extension
        acc1("sw20",  32'h20, 32'h80FF7F01, M_XWR, MT_W, 32'h0, 1'b0);
        acc1("lb22",  32'h22, 32'h0, M_XRD, MT_B,  32'hFFFFFFFF, 1'b0);
        acc1("lbu23", 32'h23, 32'h0, M_XRD, MT_BU, 32'h00000080, 1'b0);
        acc1("lh20",  32'h20, 32'h0, M_XRD, MT_H,  32'h00007F01, 1'b0);
        acc1("lh22",  32'h22, 32'h0, M_XRD, MT_H,  32'hFFFF80FF, 1'b0);
        acc1("lhu22", 32'h22, 32'h0, M_XRD, MT_HU, 32'h000080FF, 1'b0);

        // Partial stores preserve other lanes
        acc1("sw30", 32'h30, 32'h11223344, M_XWR, MT_W, 32'h0, 1'b0);
        acc1("sb31", 32'h31, 32'h000000AA, M_XWR, MT_B, 32'h0, 1'b0);
        acc1("lw30a", 32'h30, 32'h0, M_XRD, MT_W, 32'h1122AA44, 1'b0);
        acc1("sh32", 32'h32, 32'h00005566, M_XWR, MT_H, 32'h0, 1'b0);
        acc1("lw30b", 32'h30, 32'h0, M_XRD, MT_W, 32'h5566AA44, 1'b0);

        // Address aliasing modulo 4*DEPTH
        acc1("alias", 32'h4010, 32'h0, M_XRD, MT_W, 32'hDEADBEEF, 1'b0);

        // No-op functions return zero and leave memory untouched
        acc1("nop0", 32'h10, 32'h55555555, M_X,   MT_W, 32'h0, 1'b0);
        acc1("nop3", 32'h10, 32'h66666666, 2'b11, MT_W, 32'h0, 1'b0);
        acc1("lw10b", 32'h10, 32'h0, M_XRD, MT_W, 32'hDEADBEEF, 1'b0);

        // Back-to-back store then load of the same word
        @(negedge clk);
        in1 = pk(32'h50, 32'hCAFEF00D, M_XWR, MT_W);
        @(posedge clk);
        #1 in1 = pk(32'h50, 32'h0, M_XRD, MT_W);
        @(negedge clk);
        chk("b2b_st_valid", {31'd0, out1[0]}, 32'd1);
        chk("b2b_st_ready", {31'd0, out1[1]}, 32'd1);
        chk("b2b_st_data",  out1[33:2], 32'd0);
        @(posedge clk);
        #1 in1 = '0;
        @(negedge clk);
        chk("b2b_ld_valid", {31'd0, out1[0]}, 32'd1);
        chk("b2b_ld_data",  out1[33:2], 32'hCAFEF00D);

`ifdef MEMORY_RESPONDER_MISALIGN_ERR_EN
        acc1("sw40",   32'h40, 32'hA5A5A5A5, M_XWR, MT_W, 32'h0, 1'b0);
        acc1("sw41",   32'h41, 32'h12345678, M_XWR, MT_W, 32'h0, 1'b1);
        acc1("lw40",   32'h40, 32'h0, M_XRD, MT_W, 32'hA5A5A5A5, 1'b0);
        acc1("lh21",   32'h21, 32'h0, M_XRD, MT_H, 32'h0, 1'b1);
`else
        acc1("lw13",   32'h13, 32'h0, M_XRD, MT_W, 32'hDEADBEEF, 1'b0);
        acc1("lh21",   32'h21, 32'h0, M_XRD, MT_H, 32'h00007F01, 1'b0);
        acc1("sw41",   32'h41, 32'h12345678, M_XWR, MT_W, 32'h0, 1'b0);
        acc1("lw40",   32'h40, 32'h0, M_XRD, MT_W, 32'h12345678, 1'b0);
`endif

        // LATENCY=3: timing, and a request held valid through WAIT
        @(negedge clk);
        in3 = pk(32'h10, 32'h0BADF00D, M_XWR, MT_W);
        @(posedge clk);
        #1 in3 = pk(32'h10, 32'h0, M_XRD, MT_W);
        @(negedge clk);
        chk("l3_w1_ready", {31'd0, out3[1]}, 32'd0);
        chk("l3_w1_valid", {31'd0, out3[0]}, 32'd0);
        @(negedge clk);
        chk("l3_w2_ready", {31'd0, out3[1]}, 32'd0);
        chk("l3_w2_valid", {31'd0, out3[0]}, 32'd0);
        @(negedge clk);
        chk("l3_r_ready", {31'd0, out3[1]}, 32'd1);
        chk("l3_r_valid", {31'd0, out3[0]}, 32'd1);
        chk("l3_r_data",  out3[33:2], 32'd0);
        @(posedge clk);
        #1 in3 = '0;
        @(negedge clk);
        chk("l3_held_accepted", {31'd0, out3[1]}, 32'd0);
        chk("l3_hold_data",     out3[33:2], 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("l3_ld_valid", {31'd0, out3[0]}, 32'd1);
        chk("l3_ld_data",  out3[33:2], 32'h0BADF00D);

        // Reset one cycle after accepting a store
        @(negedge clk);
        in3 = pk(32'h20, 32'h00000077, M_XWR, MT_W);
        @(posedge clk);
        #1 in3 = '0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", {31'd0, out3[1]}, 32'd1);
        chk("mid_rst_valid", {31'd0, out3[0]}, 32'd0);
        chk("mid_rst_data",  out3[33:2], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seen = seen | out3[0];
        end
        chk("mid_rst_no_resp", {31'd0, seen}, 32'd0);
        acc3("l3_rb10", 32'h10, 32'h0, M_XRD, MT_W, 32'h0BADF00D);
        acc3("l3_rb20", 32'h20, 32'h0, M_XRD, MT_W, 32'h00000077);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
